// File: rtl/inertial_pkg.sv
// inertial_pkg: state encoding and default constants shared by the pitch integrator slice.
package inertial_pkg;
   typedef enum logic {RUN, CAL} state_t;
   localparam int AZ_OFFSET_DEF      = 'h00A0;
   localparam int ACC_GAIN_DEF       = 327;
   localparam int ACC_SHIFT_DEF      = 13;
   localparam int RT_OFFSET_INIT_DEF = 'h0050;
   localparam int FUSE_GAIN_DEF      = 1024;
endpackage

// File: rtl/gyro_offset_cal.sv
// gyro_offset_cal: averages 2^CAL_LOG2 vld pitch-rate samples into the gyro offset register.
module gyro_offset_cal
   import inertial_pkg::*;
#(
   parameter int DW             = 16,
   parameter int CAL_LOG2       = 4,
   parameter int RT_OFFSET_INIT = RT_OFFSET_INIT_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 vld,
   input  logic                 cal_start,
   input  logic signed [DW-1:0] ptch_rt,
   output logic                 cal_busy,
   output logic                 cal_done,
   output logic signed [DW-1:0] rt_offset
);
   localparam int AW = DW + CAL_LOG2;
   localparam logic signed [DW-1:0] OFF_INIT = DW'(RT_OFFSET_INIT);
   state_t state_q, state_d;
   logic [CAL_LOG2-1:0] cnt_q, cnt_d;
   logic signed [AW-1:0] acc_q, acc_d, acc_sum, acc_shr;
   logic signed [DW-1:0] off_q, off_d;
   logic done_q, done_d, last, clear;
   always_comb begin
      acc_sum = acc_q + AW'(ptch_rt);
      acc_shr = acc_sum >>> CAL_LOG2;
      clear   = cal_start || state_q == RUN;
      // a restart pulse discards the sample arriving with it
      last    = state_q == CAL && vld && !cal_start && &cnt_q;
      state_d = cal_start ? CAL : last ? RUN : state_q;
      cnt_d   = clear ? '0 : vld ? cnt_q + 1'b1 : cnt_q;
      acc_d   = clear ? '0 : vld ? acc_sum : acc_q;
      off_d   = last ? acc_shr[DW-1:0] : off_q;
      done_d  = last;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
         acc_q   <= '0;
         off_q   <= OFF_INIT;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         off_q   <= off_d;
         done_q  <= done_d;
      end
   end
   assign cal_busy  = state_q == CAL;
   assign cal_done  = done_q;
   assign rt_offset = off_q;
endmodule

// File: rtl/inertial_integrator_cfg.sv
// inertial_integrator_cfg: 2-stage complementary-filter pitch integrator with runtime gyro calibration.
// Define INTEG_SAT_EN to clamp the integrator instead of letting it wrap.
module inertial_integrator_cfg
   import inertial_pkg::*;
#(
   parameter int DW             = 16,
   parameter int FRAC           = 11,
   parameter int FUSE_GAIN      = FUSE_GAIN_DEF,
   parameter int AZ_OFFSET      = AZ_OFFSET_DEF,
   parameter int ACC_GAIN       = ACC_GAIN_DEF,
   parameter int ACC_SHIFT      = ACC_SHIFT_DEF,
   parameter int RT_OFFSET_INIT = RT_OFFSET_INIT_DEF,
   parameter int CAL_LOG2       = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 vld,
   input  logic signed [DW-1:0] ptch_rt,
   input  logic signed [DW-1:0] AZ,
   input  logic                 cal_start,
   output logic signed [DW-1:0] ptch,
   output logic                 ptch_vld,
   output logic                 cal_busy,
   output logic                 cal_done,
   output logic signed [DW-1:0] rt_offset
);
   localparam int IW = DW + FRAC;
   localparam logic signed [DW:0] AZ_OFF = (DW+1)'(AZ_OFFSET);
   localparam logic signed [IW:0] FG = (IW+1)'(FUSE_GAIN);
   logic signed [DW:0] rt_comp_d, rt_comp_q, az_comp;
   logic signed [DW+32:0] acc_prod, acc_shr;
   logic signed [DW-1:0] ptch_acc_d, ptch_acc_q;
   logic signed [IW:0] fuse, sum;
   logic signed [IW-1:0] integ_n, integ_d, integ_q;
   logic s1_vld_d, s1_vld_q, ptch_vld_d, ptch_vld_q;
   gyro_offset_cal #(.DW(DW), .CAL_LOG2(CAL_LOG2), .RT_OFFSET_INIT(RT_OFFSET_INIT)) u_cal (
      .clk(clk), .rst(rst), .vld(vld), .cal_start(cal_start), .ptch_rt(ptch_rt),
      .cal_busy(cal_busy), .cal_done(cal_done), .rt_offset(rt_offset)
   );
   always_comb begin
      rt_comp_d  = {ptch_rt[DW-1], ptch_rt} - {rt_offset[DW-1], rt_offset};
      az_comp    = {AZ[DW-1], AZ} - AZ_OFF;
      acc_prod   = (DW+33)'(az_comp) * (DW+33)'(ACC_GAIN);
      acc_shr    = acc_prod >>> ACC_SHIFT;
      ptch_acc_d = acc_shr[DW-1:0];
      // samples taken while calibrating belong to the calibrator only
      s1_vld_d   = vld && !cal_busy;
      fuse       = (ptch_acc_q > ptch) ? FG : -FG;
      sum        = (IW+1)'(integ_q) - (IW+1)'(rt_comp_q) + fuse;
`ifdef INTEG_SAT_EN
      integ_n    = (sum[IW] ^ sum[IW-1]) ? {sum[IW], {(IW-1){~sum[IW]}}} : sum[IW-1:0];
`else
      integ_n    = sum[IW-1:0];
`endif
      integ_d    = s1_vld_q ? integ_n : integ_q;
      ptch_vld_d = s1_vld_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         rt_comp_q  <= '0;
         ptch_acc_q <= '0;
         s1_vld_q   <= 1'b0;
         integ_q    <= '0;
         ptch_vld_q <= 1'b0;
      end else begin
         rt_comp_q  <= rt_comp_d;
         ptch_acc_q <= ptch_acc_d;
         s1_vld_q   <= s1_vld_d;
         integ_q    <= integ_d;
         ptch_vld_q <= ptch_vld_d;
      end
   end
   assign ptch     = integ_q[IW-1:FRAC];
   assign ptch_vld = ptch_vld_q;
endmodule

// File: tb/tb_inertial_integrator_cfg.sv
// tb_inertial_integrator_cfg: randomized + directed scoreboard bench against an arithmetic pitch model.
module tb_inertial_integrator_cfg;
   localparam int IW = 27, FRAC = 11, AZ_OFF = 'h00A0, RT_INIT = 'h0050;
   logic clk = 1'b0, rst, vld, cal_start;
   logic signed [15:0] ptch_rt, az, ptch, rt_offset;
   logic ptch_vld, cal_busy, cal_done;
   int n_cmp = 0, n_bad = 0;
   longint integ, cal_sum;
   int m_off, cal_n;
   bit m_cal;
   int exp_q[$];

   inertial_integrator_cfg dut (
      .clk(clk), .rst(rst), .vld(vld), .ptch_rt(ptch_rt), .AZ(az), .cal_start(cal_start),
      .ptch(ptch), .ptch_vld(ptch_vld), .cal_busy(cal_busy), .cal_done(cal_done), .rt_offset(rt_offset)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
      end
   endtask

   function automatic longint lim(input longint v);
      longint h = longint'(1) << (IW - 1);
`ifdef INTEG_SAT_EN
      return v > h - 1 ? h - 1 : v < -h ? -h : v;
`else
      return ((v + h) & (2 * h - 1)) - h;
`endif
   endfunction

   function automatic int m_ptch();
      return int'(integ >>> FRAC);
   endfunction

   // drive one cycle; the model consumes the sample the same way the spec describes
   task automatic step(input logic v, input int rt, input int a, input logic cs = 1'b0);
      vld = v; ptch_rt = 16'(rt); az = 16'(a); cal_start = cs;
      if (cs) begin
         m_cal = 1; cal_n = 0; cal_sum = 0;
      end else if (v && m_cal) begin
         cal_sum += shortint'(rt);
         cal_n++;
         if (cal_n == 16) begin
            m_off = int'(cal_sum >>> 4);
            m_cal = 0;
         end
      end else if (v) begin
         int rtc = int'(shortint'(rt)) - m_off;
         int acc = int'(shortint'(((int'(shortint'(a)) - AZ_OFF) * 327) >>> 13));
         integ = lim(integ - rtc + (acc > m_ptch() ? 1024 : -1024));
         exp_q.push_back(m_ptch());
      end
      @(posedge clk); #1;
   endtask

   task automatic do_rst(input string tag);
      rst = 1'b1;
      step(0, 0, AZ_OFF);
      rst = 1'b0;
      integ = 0; m_off = RT_INIT; m_cal = 0;
      exp_q.delete();
      chk({tag, "_ptch"}, ptch, 0);
      chk({tag, "_ptch_vld"}, ptch_vld, 0);
      chk({tag, "_cal_busy"}, cal_busy, 0);
      chk({tag, "_cal_done"}, cal_done, 0);
      chk({tag, "_rt_offset"}, rt_offset, RT_INIT);
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, AZ_OFF);
   endtask

   always @(negedge clk) begin
      if (ptch_vld) begin
         if (exp_q.size() == 0) chk("unexpected_ptch_vld", 1, 0);
         else chk("ptch", ptch, exp_q.pop_front());
      end
   end

   initial begin
      rst = 0; vld = 0; ptch_rt = 0; az = 0; cal_start = 0;
      integ = 0; m_off = RT_INIT; m_cal = 0; cal_n = 0; cal_sum = 0;
      do_rst("reset");

      repeat (500) step(1, 'h1050, AZ_OFF);
      idle(3);
      chk_rng("offset_removal", ptch, -752, -750);
      repeat (1000) step(1, 'h0050, AZ_OFF);
      idle(3);
      chk_rng("offset_hold", ptch, -252, -250);

      do_rst("reset2");
      repeat (500) step(1, 'h0050 - 'h1000, AZ_OFF);
      idle(3);
      chk_rng("symmetry", ptch, 749, 751);
      repeat (1000) step(1, 'h0050, AZ_OFF);
      idle(3);
      chk_rng("symmetry_hold", ptch, 249, 251);

      do_rst("reset3");
      repeat (3000) step(1, 'h0050, 'h0800);
      idle(3);
      chk_rng("accel_converge", ptch, 74, 76);

      repeat (600) step($urandom_range(0, 3) != 0, $urandom_range(0, 65535), $urandom_range(0, 65535));
      idle(3);

      step(1, 'h0060, AZ_OFF);
      chk("latency_1clk", ptch_vld, 0);
      step(0, 0, AZ_OFF);
      chk("latency_2clk", ptch_vld, 1);
      step(0, 0, AZ_OFF);
      chk("latency_3clk", ptch_vld, 0);

      do_rst("reset4");
      step(0, 0, AZ_OFF, 1'b1);
      chk("cal_busy_start", cal_busy, 1);
      for (int i = 0; i < 16; i++) begin
         step(1, 'h0030, AZ_OFF);
         if (i < 15) begin
            chk("cal_busy_mid", cal_busy, 1);
            chk("cal_done_mid", cal_done, 0);
         end
      end
      chk("cal_done_pulse", cal_done, 1);
      chk("cal_busy_end", cal_busy, 0);
      chk("cal_offset", rt_offset, 'h0030);
      step(0, 0, AZ_OFF);
      chk("cal_done_single", cal_done, 0);
      repeat (200) step(1, 'h0030, AZ_OFF);
      idle(3);
      chk_rng("cal_settle", ptch, -1, 1);

      step(0, 0, AZ_OFF, 1'b1);
      repeat (5) step(1, $urandom_range(0, 65535), AZ_OFF);
      step(0, 0, AZ_OFF, 1'b1);
      repeat (16) step(1, $urandom_range(0, 4095) - 2048, AZ_OFF);
      chk("cal_restart_offset", rt_offset, m_off);
      repeat (300) step($urandom_range(0, 1), $urandom_range(0, 4095) - 2048, $urandom_range(0, 65535));
      idle(3);

      step(0, 0, AZ_OFF, 1'b1);
      repeat (5) step(1, $urandom_range(0, 65535), AZ_OFF);
      chk("midcal_busy", cal_busy, 1);
      do_rst("midcal_reset");

      repeat (3000) step(1, 'h8000, AZ_OFF);
      idle(3);
`ifdef INTEG_SAT_EN
      chk("overflow_sat", ptch, 'sh7FFF);
      repeat (100) step(1, 'h8000, AZ_OFF);
      idle(3);
      chk("overflow_sat_hold", ptch, 'sh7FFF);
`else
      chk("overflow_wrap_neg", ptch < 0, 1);
`endif

      idle(3);
      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
